sysid_read_arbiter: RTL
=======================

# sysid_read_arbiter

Two-master read arbiter and sequencer for the system-ID slave, a read-only Avalon-MM slave with fixed read latency and no waitrequest. Lets the CPU data master and the debug/JTAG master share the one slave port. Serializes one read at a time, with round-robin fairness. Can optionally run a boot-time ID check against an expected value.

## Interface
Parameters:
- ADDR_W, 1, slave and master address width
- DATA_W, 32, read data width
- RD_LATENCY, 0, cycles from s_read to valid s_readdata; legal range 0..3
- EXPECTED_ID, 32'h0000_0000, value expected at address 1; the top level overrides it

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- m0_address  in  ADDR_W  master 0 address
- m0_read  in  1  master 0 read request
- m0_waitrequest  out  1  master 0 stall
- m0_readdata  out  DATA_W  master 0 data
- m1_address, m1_read, m1_waitrequest, m1_readdata: same widths and meanings, for master 1
- s_address  out  ADDR_W  slave address, registered
- s_read  out  1  slave read strobe, registered
- s_readdata  in  DATA_W  slave data
- id_done  out  1  boot check finished
- id_ok  out  1  boot ID matched EXPECTED_ID

## Operation
- The FSM has five states: BOOT, IDLE, ISSUE, WAIT, DONE.
- BOOT exists only with the macro enabled; otherwise reset enters IDLE.
- **IDLE**
  - If any mX_read is high, pick a winner.
  - Latch grant and the winner's address.
  - Go to ISSUE.
- **ISSUE**
  - s_read=1 and s_address=latched address, for exactly one cycle.
  - If RD_LATENCY=0: capture s_readdata this cycle and go to DONE.
  - Otherwise: load lat_cnt=RD_LATENCY-1 and go to WAIT.
- **WAIT**
  - s_read=0.
  - When lat_cnt=0: capture s_readdata and go to DONE.
  - Otherwise: decrement lat_cnt.
- **DONE**
  - Drive captured data on the granted mX_readdata.
  - Granted mX_waitrequest is 0 for exactly this cycle.
  - Update last_grant and return to IDLE.
- **Waitrequest:** mX_waitrequest = mX_read & ~(state==DONE & grant==X). It is combinational from state and mX_read.
- **Arbitration rules**
  - Single requester: that requester wins.
  - Both requesting: the master not equal to last_grant wins.
  - last_grant resets to 1, so m0 wins the first tie.
- **Master protocol:** a master holds address and read stable while stalled.
- **Request dropped mid-transaction:** if the granted master deasserts read, the slave access still completes. The captured data is discarded, and last_grant still updates.
- **Readdata registers:** mX_readdata holds its last captured value between transactions. Data is valid only in the DONE cycle.

## Timing
- **Read latency:** request seen in IDLE at cycle T.
  - s_read is high at T+1.
  - Capture happens at T+1+RD_LATENCY.
  - Completion (waitrequest low) happens at T+2+RD_LATENCY.
  - Stall length is 2+RD_LATENCY cycles.
- **Throughput:** one read per 3+RD_LATENCY cycles. DONE always returns to IDLE; there are no back-to-back grants without IDLE.
- **Reset values:**
  - s_read=0, s_address=0.
  - m0_readdata=0, m1_readdata=0.
  - id_done=0, id_ok=0.
  - lat_cnt=0, last_grant=1.
  - mX_waitrequest follows mX_read.
- **Reset mid-operation:** reset asserted in any state forces the reset values on the next edge. The pending read is abandoned and no DONE pulse occurs.

## Configuration
- **SYSID_BOOT_CHECK_EN defined:**
  - Reset enters BOOT.
  - BOOT issues an internal read of address 1 using the same ISSUE/WAIT timing.
  - The result is compared with EXPECTED_ID.
  - id_done goes to 1 and stays there. id_ok = (data==EXPECTED_ID).
  - The FSM then goes to IDLE.
  - Masters stall throughout BOOT.
- **SYSID_BOOT_CHECK_EN undefined:**
  - No BOOT state.
  - id_done and id_ok are driven to 1 from the first cycle after reset.
  - The ports remain present.

## Structure
- **Package sysid_arb_pkg:**
  - FSM state enum.
  - Grant encoding constants GRANT_M0=0 and GRANT_M1=1.
  - Maximum latency constant RD_LATENCY_MAX=3.
- **Sub-module sysid_rr_arbiter:** combinational two-way round-robin picker.
  - Inputs: req[1:0], last_grant.
  - Outputs: grant, any_req.

## Test plan
- **Boot check:** macro on, EXPECTED_ID=32'h54832ED3, slave model returns 32'h54832ED3 at address 1 and 0 at address 0. Required: id_done=1 and id_ok=1 at cycle 3+RD_LATENCY after reset release. A model returning 0 gives id_ok=0.
- **Single read:** RD_LATENCY=0, m0 reads address 1. Required: m0_waitrequest high for 2 cycles, then low for 1 cycle with m0_readdata=32'h54832ED3. Reading address 0 returns 0.
- **Simultaneous requests:** m0 and m1 both held continuously. Required: m0 completes first, m1 second, then strict alternation. s_read never stays high for two consecutive cycles.
- **Latency:** RD_LATENCY=2. Required: stall is 4 cycles, s_read is a one-cycle pulse, and data is captured 2 cycles after s_read.
- **Reset in WAIT:** reset asserted while the FSM is in WAIT. Required: next cycle s_read=0, readdata=0, id_done=0, with no completion pulse.
- **Dropped request:** m1 drops read during WAIT while m0 is requesting. Required: m1 gets no completion, and m0 is granted in the next IDLE.

Source files
------------

// File: rtl/sysid_arb_pkg.sv
// sysid_arb_pkg: shared FSM state type, grant encoding and latency limit for the system-ID read arbiter.
package sysid_arb_pkg;
    typedef enum logic [2:0] {BOOT, IDLE, ISSUE, WAIT, DONE} state_t;
    localparam logic GRANT_M0       = 1'b0;
    localparam logic GRANT_M1       = 1'b1;
    localparam int   RD_LATENCY_MAX = 3;
endpackage

// File: rtl/sysid_rr_arbiter.sv
// sysid_rr_arbiter: combinational two-way round-robin picker.
// Ports: req[1:0] requests in, last_grant previous winner in; grant winner out, any_req request present out.
module sysid_rr_arbiter
    import sysid_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       any_req
);
    assign any_req = |req;
    assign grant   = (&req) ? ~last_grant : (req[1] ? GRANT_M1 : GRANT_M0);
endmodule

// File: rtl/sysid_read_arbiter.sv
// sysid_read_arbiter: serializes reads from two Avalon-MM masters onto the fixed-latency system-ID slave.
// Optional boot-time ID check enabled by defining SYSID_BOOT_CHECK_EN.
// Ports: clock, reset (sync, active-high); m0_*/m1_* master ports (address, read in; waitrequest, readdata out);
//        s_address/s_read registered slave request, s_readdata slave data; id_done/id_ok boot check status.
module sysid_read_arbiter
    import sysid_arb_pkg::*;
#(
    parameter int                ADDR_W      = 1,
    parameter int                DATA_W      = 32,
    parameter int                RD_LATENCY  = 0,
    parameter logic [DATA_W-1:0] EXPECTED_ID = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    input  logic [DATA_W-1:0] s_readdata,
    output logic              id_done,
    output logic              id_ok
);
`ifdef SYSID_BOOT_CHECK_EN
    localparam logic   BOOT_EN     = 1'b1;
    localparam state_t RESET_STATE = BOOT;
`else
    localparam logic   BOOT_EN     = 1'b0;
    localparam state_t RESET_STATE = IDLE;
`endif
    localparam int LAT_W = $clog2(RD_LATENCY_MAX + 1);

    state_t           state, state_n;
    logic [LAT_W-1:0] lat_cnt;
    logic             grant, last_grant, pick, any_req, boot_q, match_q, capture, finish;

    sysid_rr_arbiter u_rr (
        .req       ({m1_read, m0_read}),
        .last_grant(last_grant),
        .grant     (pick),
        .any_req   (any_req)
    );

    // slave data is valid in ISSUE itself for zero latency, otherwise in the last WAIT cycle
    assign capture = (state == ISSUE && RD_LATENCY == 0) || (state == WAIT && lat_cnt == '0);

    always_ff @(posedge clock) begin
        if (reset) state <= RESET_STATE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            BOOT:    state_n = ISSUE;
            IDLE:    state_n = any_req ? ISSUE : IDLE;
            ISSUE:   state_n = (RD_LATENCY == 0) ? DONE : WAIT;
            WAIT:    state_n = (lat_cnt == '0) ? DONE : WAIT;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // the boot read's DONE cycle is internal and never releases a master
    always_comb begin
        finish         = state == DONE && !boot_q;
        m0_waitrequest = m0_read & ~(finish && grant == GRANT_M0);
        m1_waitrequest = m1_read & ~(finish && grant == GRANT_M1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grant       <= GRANT_M0;
            last_grant  <= GRANT_M1;
            lat_cnt     <= '0;
            s_read      <= 1'b0;
            s_address   <= '0;
            m0_readdata <= '0;
            m1_readdata <= '0;
            boot_q      <= BOOT_EN;
            match_q     <= 1'b0;
            id_done     <= 1'b0;
            id_ok       <= 1'b0;
        end else begin
            s_read <= state_n == ISSUE;
            if (state == IDLE && any_req) begin
                grant     <= pick;
                s_address <= pick ? m1_address : m0_address;
            end
            if (state == BOOT) s_address <= ADDR_W'(1);
            if (state == ISSUE && RD_LATENCY != 0) lat_cnt <= LAT_W'(RD_LATENCY - 1);
            if (state == WAIT && lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
            if (capture && boot_q) match_q <= s_readdata == EXPECTED_ID;
            // a master that dropped its request keeps its old data
            if (capture && !boot_q && grant == GRANT_M0 && m0_read) m0_readdata <= s_readdata;
            if (capture && !boot_q && grant == GRANT_M1 && m1_read) m1_readdata <= s_readdata;
            if (state == DONE && boot_q) begin
                boot_q  <= 1'b0;
                id_done <= 1'b1;
                id_ok   <= match_q;
            end
            if (state == DONE && !boot_q) last_grant <= grant;
            if (!BOOT_EN) begin
                id_done <= 1'b1;
                id_ok   <= 1'b1;
            end
        end
    end
endmodule
